// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
//   result_src_t : writeback result source (ALU, memory, PC+4)
//   alu_ctrl_t   : ALU operation encodings
//   ctrl_t       : 12-bit decode control bundle carried down the pipeline
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_BGE = 4'b1000,
    ALU_XOR = 4'b1001
  } alu_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        alu_src;
    alu_ctrl_t   alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register.
//   rs, rf_data          : registered source address and register-file value
//   m_rd/m_reg_write/m_result : EX/MEM writeback candidate (highest priority)
//   w_rd/w_reg_write/w_result : MEM/WB writeback candidate
//   fwd_data             : selected operand value (combinational)
module fwd_mux #(
  parameter int Data_Width = 32
) (
  input  logic [4:0]            rs,
  input  logic [Data_Width-1:0] rf_data,
  input  logic [4:0]            m_rd,
  input  logic                  m_reg_write,
  input  logic [Data_Width-1:0] m_result,
  input  logic [4:0]            w_rd,
  input  logic                  w_reg_write,
  input  logic [Data_Width-1:0] w_result,
  output logic [Data_Width-1:0] fwd_data
);

  logic m_hit;
  logic w_hit;

  // x0 is hard-wired zero, so a write targeting it must never be forwarded.
  assign m_hit = m_reg_write && (m_rd != 5'd0) && (m_rd == rs);
  assign w_hit = w_reg_write && (w_rd != 5'd0) && (w_rd == rs);

  always_comb begin
    fwd_data = rf_data;
    if (m_hit)      fwd_data = m_result;
    else if (w_hit) fwd_data = w_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage register with operand forwarding and load-use detect.
//   clk, rst_n (sync, active-low), stall (hold), flush (bubble, beats stall)
//   d_*        : decode-slot instruction fields to capture
//   m_*, w_*   : EX/MEM and MEM/WB writeback candidates for forwarding
//   e_valid, e_rd, e_ctrl, e_pc : registered execute-slot fields
//   e_op1, e_op2, e_store_data  : forwarded ALU operands / store data
//   load_use   : load in execute feeds an operand of the decode instruction
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  d_valid,
  input  logic [Data_Width-1:0] d_pc,
  input  logic [Data_Width-1:0] d_rs1_data,
  input  logic [Data_Width-1:0] d_rs2_data,
  input  logic [Data_Width-1:0] d_imm,
  input  logic [4:0]            d_rs1,
  input  logic [4:0]            d_rs2,
  input  logic [4:0]            d_rd,
  input  ctrl_t                 d_ctrl,
  input  logic [4:0]            m_rd,
  input  logic                  m_reg_write,
  input  logic [Data_Width-1:0] m_result,
  input  logic [4:0]            w_rd,
  input  logic                  w_reg_write,
  input  logic [Data_Width-1:0] w_result,
  output logic                  e_valid,
  output logic [Data_Width-1:0] e_op1,
  output logic [Data_Width-1:0] e_op2,
  output logic [Data_Width-1:0] e_store_data,
  output logic [Data_Width-1:0] e_pc,
  output logic [4:0]            e_rd,
  output ctrl_t                 e_ctrl,
  output logic                  load_use
);

  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [Data_Width-1:0] rs1_data_q;
  logic [Data_Width-1:0] rs2_data_q;
  logic [Data_Width-1:0] imm_q;
  logic [Data_Width-1:0] fwd_rs1;
  logic [Data_Width-1:0] fwd_rs2;

  // A flush only kills valid/control; the data fields keep their old values
  // because nothing downstream acts on them while the slot is invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid    <= 1'b0;
      e_ctrl     <= '0;
      e_rd       <= '0;
      e_pc       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
    end else if (!stall) begin
      e_valid    <= d_valid;
      e_ctrl     <= d_ctrl;
      e_rd       <= d_rd;
      e_pc       <= d_pc;
      rs1_q      <= d_rs1;
      rs2_q      <= d_rs2;
      rs1_data_q <= d_rs1_data;
      rs2_data_q <= d_rs2_data;
      imm_q      <= d_imm;
    end
  end

  fwd_mux #(.Data_Width(Data_Width)) u_fwd_rs1 (
    .rs          (rs1_q),
    .rf_data     (rs1_data_q),
    .m_rd        (m_rd),
    .m_reg_write (m_reg_write),
    .m_result    (m_result),
    .w_rd        (w_rd),
    .w_reg_write (w_reg_write),
    .w_result    (w_result),
    .fwd_data    (fwd_rs1)
  );

  fwd_mux #(.Data_Width(Data_Width)) u_fwd_rs2 (
    .rs          (rs2_q),
    .rf_data     (rs2_data_q),
    .m_rd        (m_rd),
    .m_reg_write (m_reg_write),
    .m_result    (m_result),
    .w_rd        (w_rd),
    .w_reg_write (w_reg_write),
    .w_result    (w_result),
    .fwd_data    (fwd_rs2)
  );

  assign e_op1        = fwd_rs1;
  assign e_op2        = e_ctrl.alu_src ? imm_q : fwd_rs2;
  assign e_store_data = fwd_rs2;

  assign load_use = e_valid && (e_ctrl.result_src == RES_MEM) && (e_rd != 5'd0) &&
                    ((e_rd == d_rs1) || (e_rd == d_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, d_valid;
  logic [DW-1:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
  logic [4:0]    d_rs1, d_rs2, d_rd;
  ctrl_t         d_ctrl;
  logic [4:0]    m_rd, w_rd;
  logic          m_reg_write, w_reg_write;
  logic [DW-1:0] m_result, w_result;
  logic          e_valid, load_use;
  logic [DW-1:0] e_op1, e_op2, e_store_data, e_pc;
  logic [4:0]    e_rd;
  ctrl_t         e_ctrl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.Data_Width(DW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .d_valid(d_valid), .d_pc(d_pc), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
    .d_imm(d_imm), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_ctrl(d_ctrl),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .m_result(m_result),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
    .e_valid(e_valid), .e_op1(e_op1), .e_op2(e_op2), .e_store_data(e_store_data),
    .e_pc(e_pc), .e_rd(e_rd), .e_ctrl(e_ctrl), .load_use(load_use)
  );

  // Reference: the instruction sitting in the execute slot, as plain fields.
  // Control is kept as a raw 12-bit word in documented field order:
  // [11] reg_write [10] mem_write [9:8] result_src [4] alu_src [3:0] alu_ctrl.
  typedef struct {
    bit            valid;
    bit [11:0]     ctrl;
    bit [4:0]      rd, rs1, rs2;
    bit [DW-1:0]   pc, a, b, imm;
  } slot_t;

  slot_t slot;

  function automatic logic [DW-1:0] pick(input bit [4:0] rs, input bit [DW-1:0] rf);
    if (rs == 0)                            return rf;
    if (m_reg_write === 1'b1 && m_rd == rs) return m_result;
    if (w_reg_write === 1'b1 && w_rd == rs) return w_result;
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] op1, op2, sd;
    bit            lu;
    op1 = pick(slot.rs1, slot.a);
    sd  = pick(slot.rs2, slot.b);
    op2 = slot.ctrl[4] ? slot.imm : sd;
    lu  = slot.valid && slot.ctrl[9:8] == 2'b01 && slot.rd != 0 &&
          (slot.rd == d_rs1 || slot.rd == d_rs2);
    chk({tag, ".valid"}, 64'(e_valid), 64'(slot.valid));
    chk({tag, ".ctrl"},  64'(e_ctrl),  64'(slot.ctrl));
    chk({tag, ".rd"},    64'(e_rd),    64'(slot.rd));
    chk({tag, ".pc"},    64'(e_pc),    64'(slot.pc));
    chk({tag, ".op1"},   64'(e_op1),   64'(op1));
    chk({tag, ".op2"},   64'(e_op2),   64'(op2));
    chk({tag, ".sd"},    64'(e_store_data), 64'(sd));
    chk({tag, ".lu"},    64'(load_use), 64'(lu));
  endtask

  // One rising edge: advance the reference from the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      slot = '{default: 0};
    end else if (flush) begin
      slot.valid = 0;
      slot.ctrl  = 0;
    end else if (!stall) begin
      slot.valid = d_valid;
      slot.ctrl  = 12'(d_ctrl);
      slot.rd    = d_rd;
      slot.rs1   = d_rs1;
      slot.rs2   = d_rs2;
      slot.pc    = d_pc;
      slot.a     = d_rs1_data;
      slot.b     = d_rs2_data;
      slot.imm   = d_imm;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; d_valid = 0;
    d_pc = '0; d_rs1_data = '0; d_rs2_data = '0; d_imm = '0;
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_ctrl = '0;
    m_rd = '0; m_reg_write = 0; m_result = '0;
    w_rd = '0; w_reg_write = 0; w_result = '0;
  endtask

  task automatic rand_decode();
    d_valid    = 1'($urandom);
    d_pc       = $urandom;
    d_rs1_data = $urandom;
    d_rs2_data = $urandom;
    d_imm      = $urandom;
    d_rs1      = 5'($urandom_range(0, 7));
    d_rs2      = 5'($urandom_range(0, 7));
    d_rd       = 5'($urandom_range(0, 7));
    d_ctrl     = ctrl_t'(12'($urandom));
  endtask

  initial begin
    logic [DW-1:0] hold_pc;
    slot = '{default: 0};
    idle_inputs();
    rst_n = 0;
    d_pc = 32'hDEAD; d_valid = 1;
    cycle(); cycle();
    check_all("reset");
    chk("reset_op1", 64'(e_op1), 0);
    chk("reset_lu", 64'(load_use), 0);
    rst_n = 1;

    // Capture with immediate operand
    d_valid = 1; d_rs1 = 1; d_rs1_data = 5; d_imm = 7; d_pc = 32'h100; d_rd = 2;
    d_ctrl = '0; d_ctrl.alu_src = 1; d_ctrl.alu_ctrl = ALU_ADD;
    cycle();
    chk("cap_op1", 64'(e_op1), 5);
    chk("cap_op2", 64'(e_op2), 7);
    chk("cap_valid", 64'(e_valid), 1);
    check_all("cap");

    // Forwarding priority on rs1
    d_rs1 = 3; d_rs1_data = 32'h11;
    cycle();
    m_rd = 3; m_reg_write = 1; m_result = 32'hAA;
    w_rd = 3; w_reg_write = 1; w_result = 32'hBB;
    #1;
    chk("prio_mem", 64'(e_op1), 32'hAA);
    check_all("prio_mem");
    m_reg_write = 0; #1;
    chk("prio_wb", 64'(e_op1), 32'hBB);
    check_all("prio_wb");
    w_reg_write = 0;

    // x0 never forwards
    d_rs2 = 0; d_rs2_data = 32'h66; d_ctrl.alu_src = 0;
    cycle();
    m_rd = 0; m_reg_write = 1; m_result = 32'h55; #1;
    chk("x0_op2", 64'(e_op2), 32'h66);
    chk("x0_sd", 64'(e_store_data), 32'h66);
    m_reg_write = 0;

    // Load-use, then stall+flush together
    d_rd = 4; d_ctrl = '0; d_ctrl.result_src = RES_MEM; d_ctrl.reg_write = 1; d_valid = 1;
    cycle();
    d_rs1 = 9; d_rs2 = 4; #1;
    chk("lu_hit", 64'(load_use), 1);
    check_all("lu_hit");
    stall = 1; flush = 1;
    cycle();
    chk("lu_flush_valid", 64'(e_valid), 0);
    chk("lu_flush_lu", 64'(load_use), 0);
    check_all("lu_flush");
    stall = 0; flush = 0;

    // Stall hold with live forwarding from MEM/WB
    d_rs1 = 5; d_rs1_data = 32'h1234; d_pc = 32'h200; d_ctrl = '0; d_valid = 1;
    cycle();
    hold_pc = e_pc;
    stall = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      rand_decode();
      cycle();
      chk("stall_pc", 64'(e_pc), 32'h200);
      w_rd = 5; w_reg_write = 1; w_result = 32'hC0DE_0000 + i; #1;
      chk("stall_fwd", 64'(e_op1), 64'(32'hC0DE_0000 + i));
      check_all("stall");
    end
    chk("stall_pc_end", 64'(e_pc), 64'(hold_pc));
    stall = 0; w_reg_write = 0;

    // Reset mid-stream with stall held
    rand_decode(); d_valid = 1;
    cycle();
    rst_n = 0; stall = 1; flush = 0;
    cycle();
    chk("rst_mid_valid", 64'(e_valid), 0);
    chk("rst_mid_pc", 64'(e_pc), 0);
    chk("rst_mid_lu", 64'(load_use), 0);
    check_all("rst_mid");
    rst_n = 1; stall = 0;

    // Randomized traffic against the reference
    for (int unsigned n = 0; n < 500; n++) begin
      rand_decode();
      rst_n       = ($urandom_range(0, 49) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      m_rd        = 5'($urandom_range(0, 7));
      m_reg_write = 1'($urandom);
      m_result    = $urandom;
      w_rd        = 5'($urandom_range(0, 7));
      w_reg_write = 1'($urandom);
      w_result    = $urandom;
      #1;
      check_all("rand_pre");
      cycle();
      check_all("rand_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter Data_Width, default 32, the width of operands, PC and results.
REQ-002 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port stall  in  1  hold the stage register.
REQ-005 The block SHALL have port flush  in  1  load a bubble into the stage register.
REQ-006 The block SHALL have port d_valid  in  1  decode slot holds a real instruction.
REQ-007 The block SHALL have ports d_pc, d_rs1_data, d_rs2_data, d_imm  in  Data_Width each  decode PC, register-file reads and sign-extended immediate.
REQ-008 The block SHALL have ports d_rs1, d_rs2, d_rd  in  5 each  decode register addresses.
REQ-009 The block SHALL have port d_ctrl  in  ctrl_t (12)  decode control bundle {reg_write, mem_write, result_src[1:0], branch, jump, jalr, alu_src, alu_ctrl[3:0]}.
REQ-010 The block SHALL have ports m_rd  in  5 / m_reg_write  in  1 / m_result  in  Data_Width  EX/MEM writeback candidate.
REQ-011 The block SHALL have ports w_rd  in  5 / w_reg_write  in  1 / w_result  in  Data_Width  MEM/WB writeback candidate.
REQ-012 The block SHALL have port e_valid  out  1  execute slot valid.
REQ-013 The block SHALL have ports e_op1, e_op2  out  Data_Width each  ALU operands.
REQ-014 The block SHALL have ports e_store_data, e_pc  out  Data_Width each  forwarded rs2 for stores; PC of the execute instruction.
REQ-015 The block SHALL have ports e_rd  out  5 / e_ctrl  out  ctrl_t  registered destination and control.
REQ-016 The block SHALL have port load_use  out  1  load-use hazard request to the hazard unit.

Function
REQ-017 On each rising clk with rst_n=1, flush=1 the stage SHALL load a bubble: e_valid=0 and e_ctrl=0; data registers hold. flush takes priority over stall.
REQ-018 With flush=0, stall=1 all stage registers SHALL hold their values.
REQ-019 With flush=0, stall=0 all stage registers SHALL capture the d_* inputs; latency decode-to-execute is exactly 1 cycle.
REQ-020 Registered rs1/rs2 addresses SHALL be retained internally for forwarding.
REQ-021 Forwarding per operand SHALL be combinational: select m_result if m_reg_write=1, m_rd!=0 and m_rd equals the registered address; else w_result under the same rule with w_*; else the registered register-file value.
REQ-022 EX/MEM SHALL win when both candidates match; address x0 SHALL never forward.
REQ-023 Forwarding SHALL re-evaluate every cycle, including stalled cycles, against current m_*/w_* inputs.
REQ-024 Operands: e_op1 = forwarded rs1; e_op2 = registered imm when e_ctrl.alu_src=1, else forwarded rs2; e_store_data = forwarded rs2 always.
REQ-025 load_use SHALL be combinational = e_valid AND e_ctrl.result_src==RES_MEM AND e_rd!=0 AND (e_rd==d_rs1 OR e_rd==d_rs2).
REQ-026 load_use SHALL be 0 whenever e_valid=0, including the cycle after a flush.

Reset
REQ-027 On rising clk with rst_n=0 the stage SHALL clear all registers (e_valid, e_ctrl, e_rd, e_pc, data, internal rs addresses) to 0; reset overrides flush and stall.
REQ-028 After reset, before any capture: e_op1=e_op2=e_store_data=0 and load_use=0.

Structure
REQ-029 ctrl_t, the RES_ALU/RES_MEM/RES_PC4 encodings and the ALU_ctrl encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SRL 0110, SRA 0111, BGE 1000, XOR 1001) SHALL live in shared package riscv_pkg.
REQ-030 The forwarding selection SHALL be one sub-module, fwd_mux, instantiated once per source operand.

Verification
REQ-031 Capture: d_rs1_data=5, d_imm=7, alu_src=1, alu_ctrl=ADD, no forwarding -> next cycle e_op1=5, e_op2=7, e_valid=1.
REQ-032 Priority: registered rs1=3, m_rd=3/m_reg_write=1/m_result=0xAA, w_rd=3/w_reg_write=1/w_result=0xBB -> e_op1=0xAA; m_reg_write=0 -> e_op1=0xBB.
REQ-033 x0: registered rs2=0, m_rd=0/m_reg_write=1/m_result=0x55, alu_src=0 -> e_op2=e_store_data=registered rs2 data.
REQ-034 Load-use: e_ctrl.result_src=RES_MEM, e_rd=4, e_valid=1, d_rs2=4 -> load_use=1; assert stall and flush together -> next cycle e_valid=0, load_use=0.
REQ-035 Stall hold: stall=1 for 3 cycles with changing d_* -> e_* registers unchanged; w_result change during the stall is visible on the matching forwarded operand the same cycle.
REQ-036 Reset mid-stream: rst_n=0 with stall=1 and flush=0 -> next cycle all outputs 0, load_use=0.
